// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with runtime baud, parity and stop-bit selection.
// Received frames are held with their error flags until the consumer acknowledges them.
module uart_rx_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           baud_select,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    input  logic                 Rx_ACK,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_FERROR,
    output logic                 Rx_PERROR,
    output logic                 Rx_OERROR
);
    function automatic int div_of(input int baud);
        int d;
        d = (CLK_FREQ + baud * OVERSAMPLE / 2) / (baud * OVERSAMPLE);
        return d < 1 ? 1 : d;
    endfunction

    localparam int DW = $clog2(div_of(300) + 1);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [DW-1:0] DIV_M1 [8] = '{
        DW'(div_of(300) - 1),   DW'(div_of(1200) - 1),  DW'(div_of(4800) - 1),  DW'(div_of(9600) - 1),
        DW'(div_of(19200) - 1), DW'(div_of(38400) - 1), DW'(div_of(57600) - 1), DW'(div_of(115200) - 1)
    };

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t               state_q, state_d;
    logic                 rx1_q, rx1_d, rx2_q, rx2_d, rxp_q, rxp_d;
    logic [DW-1:0]        tcnt_q, tcnt_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [2:0]           baud_q, baud_d;
    logic [1:0]           par_q, par_d;
    logic                 two_q, two_d, fer_q, fer_d, per_q, per_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d, oerr_q, oerr_d;
    logic                 tick, bit_end, vote_t, v, done;

    always_comb begin
        rx1_d   = RxD;
        rx2_d   = rx1_q;
        rxp_d   = rx2_q;
        state_d = state_q;
        bcnt_d  = bcnt_q;
        smp_d   = smp_q;
        sh_d    = sh_q;
        baud_d  = baud_q;
        par_d   = par_q;
        two_d   = two_q;
        fer_d   = fer_q;
        per_d   = per_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        oerr_d  = oerr_q;
        done    = 1'b0;
        tick    = state_q != IDLE && tcnt_q == DIV_M1[baud_q];
        bit_end = tick && scnt_q == SW'(OVERSAMPLE - 1);
        vote_t  = tick && scnt_q == SW'(OVERSAMPLE / 2 + 1);
        v       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx2_q) | (smp_q[1] & rx2_q);
        tcnt_d  = (state_q == IDLE || tick) ? '0 : tcnt_q + 1'b1;
        scnt_d  = bit_end ? '0 : tick ? scnt_q + 1'b1 : scnt_q;
        if (tick && scnt_q == SW'(OVERSAMPLE / 2 - 1)) smp_d[0] = rx2_q;
        if (tick && scnt_q == SW'(OVERSAMPLE / 2)) smp_d[1] = rx2_q;
        case (state_q)
            IDLE: if (Rx_EN && rxp_q && !rx2_q) begin
                state_d = START;
                scnt_d  = '0;
                bcnt_d  = '0;
                baud_d  = baud_select;
                par_d   = parity_mode;
                two_d   = two_stop;
                fer_d   = 1'b0;
                per_d   = 1'b0;
            end
            START: state_d = (vote_t && v) ? IDLE : bit_end ? DATA : START;
            DATA: begin
                if (vote_t) begin
                    sh_d   = {v, sh_q[DATA_BITS-1:1]};
                    bcnt_d = bcnt_q + 1'b1;
                end
                if (bit_end && bcnt_q == BW'(DATA_BITS)) state_d = ^par_q ? PARITY : STOP1;
            end
            PARITY: begin
                if (vote_t) per_d = ^sh_q ^ v ^ par_q[1];
                if (bit_end) state_d = STOP1;
            end
            STOP1: begin
                if (vote_t) begin
                    fer_d = fer_q | ~v;
                    done  = ~two_q;
                end
                if (bit_end && two_q) state_d = STOP2;
            end
            STOP2: if (vote_t) begin
                fer_d = fer_q | ~v;
                done  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (!Rx_EN) done = 1'b0;
        if (done || !Rx_EN) state_d = IDLE;
        // Completion beats a coincident ACK; the ACK then only suppresses overrun.
        if (done) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            ferr_d  = fer_d;
            perr_d  = per_q;
            oerr_d  = valid_q & ~Rx_ACK;
        end else if (Rx_ACK && valid_q) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
            oerr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rx1_q   <= 1'b1;
            rx2_q   <= 1'b1;
            rxp_q   <= 1'b1;
            tcnt_q  <= '0;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            smp_q   <= '0;
            sh_q    <= '0;
            baud_q  <= '0;
            par_q   <= '0;
            two_q   <= 1'b0;
            fer_q   <= 1'b0;
            per_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rx1_q   <= rx1_d;
            rx2_q   <= rx2_d;
            rxp_q   <= rxp_d;
            tcnt_q  <= tcnt_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            smp_q   <= smp_d;
            sh_q    <= sh_d;
            baud_q  <= baud_d;
            par_q   <= par_d;
            two_q   <= two_d;
            fer_q   <= fer_d;
            per_q   <= per_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            oerr_q  <= oerr_d;
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_FERROR = ferr_q;
    assign Rx_PERROR = perr_q;
    assign Rx_OERROR = oerr_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and randomized frames against a frame-level model of the held outputs.
module tb_uart_rx_param;
    localparam int CLK_FREQ = 7_372_800;
    localparam int BAUD     = 115_200;
    localparam int BP       = ((CLK_FREQ + BAUD * 8) / (BAUD * 16)) * 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] baud_select = 3'd7;
    logic [1:0] parity_mode = 2'd0;
    logic       two_stop = 1'b0;
    logic       Rx_EN = 1'b1;
    logic       RxD = 1'b1;
    logic       Rx_ACK = 1'b0;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID, Rx_FERROR, Rx_PERROR, Rx_OERROR;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_d = '0;
    logic       exp_v = 1'b0, exp_f = 1'b0, exp_p = 1'b0, exp_o = 1'b0;

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .baud_select(baud_select), .parity_mode(parity_mode),
        .two_stop(two_stop), .Rx_EN(Rx_EN), .RxD(RxD), .Rx_ACK(Rx_ACK), .Rx_DATA(Rx_DATA),
        .Rx_VALID(Rx_VALID), .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR), .Rx_OERROR(Rx_OERROR)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"}, 32'(Rx_DATA), 32'(exp_d));
        check({tag, ".valid"}, 32'(Rx_VALID), 32'(exp_v));
        check({tag, ".ferr"}, 32'(Rx_FERROR), 32'(exp_f));
        check({tag, ".perr"}, 32'(Rx_PERROR), 32'(exp_p));
        check({tag, ".oerr"}, 32'(Rx_OERROR), 32'(exp_o));
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic good_par(input logic [7:0] w, input logic [1:0] pm);
        return ^w ^ (pm == 2'b10);
    endfunction

    // Drives the first nbits line bits of a frame; a complete frame updates the model.
    task automatic send_frame(input logic [7:0] w, input logic [1:0] pm, input logic ts,
                              input logic pbit, input logic s1, input logic s2, input int nbits);
        logic q[$];
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(w[i]);
        if (^pm) q.push_back(pbit);
        q.push_back(s1);
        if (ts) q.push_back(s2);
        baud_select = 3'd7;
        parity_mode = pm;
        two_stop = ts;
        for (int i = 0; i < q.size() && i < nbits; i++) begin
            RxD = q[i];
            if (i == 1) begin
                baud_select = 3'($urandom);
                parity_mode = 2'($urandom);
                two_stop = 1'($urandom);
            end
            wait_n(BP);
        end
        baud_select = 3'd7;
        if (nbits >= q.size()) begin
            RxD = 1'b1;
            exp_o = exp_v;
            exp_v = 1'b1;
            exp_d = w;
            exp_p = (^pm) && ((^w ^ pbit) != (pm == 2'b10));
            exp_f = !s1 || (ts && !s2);
            wait_n(8);
        end
    endtask

    task automatic ack();
        Rx_ACK = 1'b1;
        wait_n(1);
        Rx_ACK = 1'b0;
        if (exp_v) {exp_v, exp_f, exp_p, exp_o} = '0;
        wait_n(1);
    endtask

    initial begin
        wait_n(3);
        reset = 1'b0;
        wait_n(1);
        check_all("reset");

        send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 99);
        check_all("8n1_a5");
        ack();
        check_all("8n1_ack");

        send_frame(8'h53, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 99);
        check_all("even_bad");
        ack();
        send_frame(8'h53, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 99);
        check_all("even_ok");
        ack();

        send_frame(8'h3C, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 99);
        check_all("stop2_low");
        ack();
        send_frame(8'h3C, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 99);
        check_all("stop1_low");
        ack();

        RxD = 1'b0;
        wait_n(12);
        RxD = 1'b1;
        wait_n(BP * 11);
        check_all("glitch");
        send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 99);
        check_all("after_glitch");
        ack();

        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 99);
        wait_n(20);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 99);
        check_all("overrun");
        ack();
        check_all("overrun_ack");
        ack();
        check_all("idle_ack");

        send_frame(8'h99, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 99);
        send_frame(8'h5B, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5);
        RxD = 1'b1;
        wait_n(BP / 2);
        reset = 1'b1;
        wait_n(1);
        reset = 1'b0;
        {exp_d, exp_v, exp_f, exp_p, exp_o} = '0;
        check_all("reset_mid");
        wait_n(BP * 12);
        check_all("reset_no_done");
        send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 99);
        check_all("after_reset");
        ack();

        send_frame(8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        Rx_EN = 1'b0;
        wait_n(2);
        Rx_EN = 1'b1;
        RxD = 1'b1;
        wait_n(BP * 10);
        check_all("en_drop");

        Rx_EN = 1'b0;
        RxD = 1'b0;
        wait_n(10);
        Rx_EN = 1'b1;
        wait_n(BP * 3);
        RxD = 1'b1;
        wait_n(BP * 10);
        check_all("en_rise_low");

        for (int n = 0; n < 24; n++) begin
            logic [7:0] w;
            logic [1:0] pm;
            logic       ts, pb;
            w  = 8'($urandom);
            pm = 2'($urandom_range(0, 3));
            ts = 1'($urandom_range(0, 1));
            pb = good_par(w, pm) ^ ($urandom_range(0, 3) == 0);
            send_frame(w, pm, ts, pb, $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, 99);
            check_all($sformatf("rand%0d", n));
            if ($urandom_range(0, 1) == 1) begin
                ack();
                check_all($sformatf("rand%0d_ack", n));
            end
            wait_n($urandom_range(5, 40));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLK_FREQ, 100_000_000, system clock frequency in Hz.
REQ-002 Parameter DATA_BITS, 8, data bits per frame; legal range 5..9.
REQ-003 Parameter OVERSAMPLE, 16, sample ticks per bit; even, legal range 8..32.
REQ-004 Port clk  input  1  system clock; all logic on the rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port baud_select  input  3  baud rate index: 0..7 = 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200.
REQ-007 Port parity_mode  input  2  parity setting: 00 none, 01 even, 10 odd, 11 none.
REQ-008 Port two_stop  input  1  1 = two stop bits expected, 0 = one stop bit.
REQ-009 Port Rx_EN  input  1  receiver enable.
REQ-010 Port RxD  input  1  asynchronous serial input; idle level is high.
REQ-011 Port Rx_ACK  input  1  consumer acknowledge for held data.
REQ-012 Port Rx_DATA  output  DATA_BITS  received word, LSB first on the line.
REQ-013 Port Rx_VALID  output  1  data held and valid.
REQ-014 Port Rx_FERROR  output  1  framing error on the held frame.
REQ-015 Port Rx_PERROR  output  1  parity error on the held frame.
REQ-016 Port Rx_OERROR  output  1  overrun: the held frame replaced an unacknowledged one.

Function
REQ-017 RxD SHALL pass through a 2-flop synchroniser before any use; all following references mean the synchronised value.
REQ-018 An internal tick counter SHALL emit a one-cycle tick every DIV = round(CLK_FREQ/(baud*OVERSAMPLE)) cycles; DIV is a per-index constant table.
REQ-019 The tick counter SHALL reload to 0 on start detection, so ticks are phase-aligned to the start edge.
REQ-020 FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-021 Transitions: IDLE->START on a high-to-low RxD transition while Rx_EN=1.
REQ-022 START->DATA when the start bit votes 0; START->IDLE when it votes 1 (false start, no flags).
REQ-023 DATA->PARITY after DATA_BITS bits if parity is enabled, otherwise DATA->STOP1.
REQ-024 PARITY->STOP1; STOP1->STOP2 if two_stop=1; STOP1 or STOP2 (final stop) ->IDLE.
REQ-025 baud_select, parity_mode and two_stop SHALL be latched at start detection; changes mid-frame have no effect on that frame.
REQ-026 Each bit value SHALL be the 2-of-3 majority of samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit; a bit lasts OVERSAMPLE ticks.
REQ-027 Data bits SHALL shift in LSB first.
REQ-028 Parity checks: even parity requires XOR(data, parity bit)=0; odd parity requires XOR=1; a mismatch sets the frame's PERROR.
REQ-029 Any stop bit voting 0 SHALL set the frame's FERROR; with two_stop=1, each stop bit is checked.
REQ-030 Completion occurs at the final stop-bit vote; the frame is then always delivered, errors included.
REQ-031 On completion, the cycle after the final vote: Rx_DATA<=word; Rx_VALID<=1; Rx_FERROR and Rx_PERROR <= frame flags; Rx_OERROR<=Rx_VALID&~Rx_ACK (prior value).
REQ-032 Outputs SHALL hold until Rx_ACK=1 is seen while Rx_VALID=1; next cycle Rx_VALID and all three error flags clear, and Rx_DATA holds.
REQ-033 Rx_ACK coinciding with a completion: the completion wins; the new frame is presented with Rx_OERROR=0.
REQ-034 Rx_ACK while Rx_VALID=0 SHALL be ignored.
REQ-035 Rx_EN=0 SHALL force the FSM to IDLE the next cycle and discard any partial frame; held outputs are unaffected and the ACK handshake still works.
REQ-036 In IDLE with Rx_EN=1, a low RxD present when Rx_EN rises SHALL NOT trigger a start; a fresh falling edge is required.

Reset
REQ-037 On reset=1 at a clock edge: FSM=IDLE; tick and bit counters=0; synchroniser flops=1; Rx_DATA=0; Rx_VALID=Rx_FERROR=Rx_PERROR=Rx_OERROR=0.
REQ-038 Reset SHALL take priority over all other inputs, including mid-frame, and discard any partial frame.

Verification (bench: CLK_FREQ=7_372_800, OVERSAMPLE=16, baud_select=7 -> DIV=4)
REQ-039 8N1 frame 0xA5 -> Rx_DATA=0xA5, Rx_VALID=1, FERROR/PERROR/OERROR=0; pulse Rx_ACK -> Rx_VALID=0 next cycle.
REQ-040 Even parity, 0x53 sent with parity bit 1 -> Rx_DATA=0x53, Rx_VALID=1, Rx_PERROR=1; same frame with parity bit 0 -> Rx_PERROR=0.
REQ-041 two_stop=1, 0x3C with the second stop bit 0 -> Rx_VALID=1, Rx_FERROR=1; the first stop bit alone at 0 also gives Rx_FERROR=1.
REQ-042 RxD low for 3 ticks only, then high -> FSM returns to IDLE, Rx_VALID stays 0; a following 0x81 frame is received correctly.
REQ-043 Frames 0x11 then 0x22 with no ACK -> Rx_DATA=0x22, Rx_OERROR=1; ACK clears Rx_VALID and Rx_OERROR.
REQ-044 Reset asserted during data bit 4 of a frame -> all outputs 0 next cycle, no completion; next frame 0x5A -> Rx_DATA=0x5A, Rx_VALID=1.
